// File: rtl/fifo_write_ctrl_pkg.sv
// fifo_write_ctrl_pkg: shared queue defaults so read and write controllers agree on pointer format
package fifo_write_ctrl_pkg;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_CNT_W  = 8;
endpackage

// File: rtl/fifo_write_ctrl_sat_counter.sv
// sat_counter: saturating event counter, clear-then-increment when both requested
module sat_counter
    import fifo_write_ctrl_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= inc ? (clr ? W'(1) : (&cnt ? cnt : cnt + 1'b1)) : (clr ? '0 : cnt);
endmodule

// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl: write-side queue controller with occupancy flags, overflow tracking and flush
module fifo_write_ctrl
    import fifo_write_ctrl_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int AFULL_TH = 2**ADDR_W - 2,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              flush,
    input  logic              ovf_clr,
    input  logic [ADDR_W:0]   rd_ptr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W:0]   wr_ptr,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              almost_full,
    output logic              overflow,
    output logic              ptr_err,
    output logic [CNT_W-1:0]  drop_cnt
);
    localparam logic [ADDR_W:0] AF = (ADDR_W+1)'(AFULL_TH);
    logic drop;
    logic overrun;
    assign level       = wr_ptr - rd_ptr;
    // MSB set covers both level == DEPTH and a read-side overrun, so writes stay blocked either way
    assign full        = level[ADDR_W];
    assign overrun     = level[ADDR_W] & |level[ADDR_W-1:0];
    assign almost_full = level >= AF;
    assign wr_en       = push & ~full & ~flush & rst_n;
    assign drop        = push & full & ~flush;
    assign wr_addr     = wr_ptr[ADDR_W-1:0];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr   <= '0;
            overflow <= 1'b0;
            ptr_err  <= 1'b0;
        end else begin
            wr_ptr   <= flush ? rd_ptr : (wr_en ? wr_ptr + 1'b1 : wr_ptr);
            overflow <= drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow);
            ptr_err  <= overrun ? 1'b1 : (ovf_clr ? 1'b0 : ptr_err);
        end
    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ovf_clr),
        .inc   (drop),
        .cnt   (drop_cnt)
    );
endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb_fifo_write_ctrl: directed vector table plus randomized reference-model check of fifo_write_ctrl
module tb_fifo_write_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push = 1'b0;
    logic       flush = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [2:0] rd_ptr = '0;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [2:0] wr_ptr;
    logic [2:0] level;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic       ptr_err;
    logic [1:0] drop_cnt;

    int n_chk = 0;
    int n_fail = 0;

    fifo_write_ctrl #(.ADDR_W(2), .AFULL_TH(2), .CNT_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .flush       (flush),
        .ovf_clr     (ovf_clr),
        .rd_ptr      (rd_ptr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_ptr      (wr_ptr),
        .level       (level),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .ptr_err     (ptr_err),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         p, f, c;
        logic [2:0] rd;
        bit         en;
        logic [2:0] lvl;
        bit         fu, af;
        logic [2:0] wp;
        bit         ov, pe;
        logic [1:0] dc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input bit p, f, c, input logic [2:0] rd, input bit en, input logic [2:0] lvl,
                       input bit fu, af, input logic [2:0] wp, input bit ov, pe, input logic [1:0] dc);
        vec_t v;
        v = '{p, f, c, rd, en, lvl, fu, af, wp, ov, pe, dc};
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        push = 0; flush = 0; ovf_clr = 0; rd_ptr = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // behavioural reference state
    int m_wp, m_ovf, m_pe, m_dc;

    initial begin
        logic [2:0] cur_wp;
        do_reset();
        rst_n = 0;
        push = 1;
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_ptr", wr_ptr, 0);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_ptr_err", ptr_err, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        do_reset();

        //   p f c rd  en lvl fu af  wp ov pe dc
        add(1,0,0,0, 1,0, 0,0, 1, 0,0,0);
        add(1,0,0,0, 1,1, 0,0, 2, 0,0,0);
        add(1,0,0,0, 1,2, 0,1, 3, 0,0,0);
        add(1,0,0,0, 1,3, 0,1, 4, 0,0,0);
        add(1,0,0,0, 0,4, 1,1, 4, 1,0,1);
        add(1,0,0,0, 0,4, 1,1, 4, 1,0,2);
        add(1,0,0,0, 0,4, 1,1, 4, 1,0,3);
        add(1,0,0,0, 0,4, 1,1, 4, 1,0,3);
        add(1,0,0,0, 0,4, 1,1, 4, 1,0,3);
        add(1,0,1,0, 0,4, 1,1, 4, 1,0,1);
        add(1,0,0,1, 1,3, 0,1, 5, 1,0,1);
        add(1,0,0,2, 1,3, 0,1, 6, 1,0,1);
        add(1,0,0,3, 1,3, 0,1, 7, 1,0,1);
        add(1,0,0,4, 1,3, 0,1, 0, 1,0,1);
        add(0,0,0,4, 0,4, 1,1, 0, 1,0,1);
        add(0,1,0,4, 0,4, 1,1, 4, 1,0,1);
        add(1,1,0,1, 0,3, 0,1, 1, 1,0,1);
        add(0,0,0,1, 0,0, 0,0, 1, 1,0,1);
        add(0,1,0,0, 0,1, 0,0, 0, 1,0,1);
        add(0,0,0,5, 0,3, 0,1, 0, 1,0,1);
        add(0,0,0,3, 0,5, 1,1, 0, 1,1,1);
        add(1,0,0,3, 0,5, 1,1, 0, 1,1,2);
        add(0,0,1,0, 0,0, 0,0, 0, 0,0,0);

        cur_wp = 0;
        foreach (vecs[i]) begin
            push = vecs[i].p; flush = vecs[i].f; ovf_clr = vecs[i].c; rd_ptr = vecs[i].rd;
            @(negedge clk);
            chk($sformatf("v%0d_wr_en", i), wr_en, vecs[i].en);
            chk($sformatf("v%0d_level", i), level, vecs[i].lvl);
            chk($sformatf("v%0d_full", i), full, vecs[i].fu);
            chk($sformatf("v%0d_afull", i), almost_full, vecs[i].af);
            chk($sformatf("v%0d_wr_addr", i), wr_addr, cur_wp[1:0]);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wr_ptr", i), wr_ptr, vecs[i].wp);
            chk($sformatf("v%0d_overflow", i), overflow, vecs[i].ov);
            chk($sformatf("v%0d_ptr_err", i), ptr_err, vecs[i].pe);
            chk($sformatf("v%0d_drop_cnt", i), drop_cnt, vecs[i].dc);
            cur_wp = vecs[i].wp;
        end

        // reset in the middle of a burst takes effect without waiting for a clock
        do_reset();
        push = 1;
        repeat (2) @(posedge clk);
        #1 chk("burst_wr_ptr", wr_ptr, 2);
        #2 rst_n = 0;
        #1;
        chk("midrst_wr_ptr", wr_ptr, 0);
        chk("midrst_wr_en", wr_en, 0);
        @(posedge clk);
        #1 chk("midrst_hold", wr_ptr, 0);

        do_reset();
        m_wp = 0; m_ovf = 0; m_pe = 0; m_dc = 0;
        for (int n = 0; n < 400; n++) begin
            int lvl, en, drop, perr_ev;
            push    = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 11) == 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            rd_ptr  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7))
                                                   : 3'((m_wp - $urandom_range(0, 4) + 8) % 8);
            lvl     = (m_wp - int'(rd_ptr) + 8) % 8;
            en      = (push && lvl < 4 && !flush) ? 1 : 0;
            drop    = (push && lvl >= 4 && !flush) ? 1 : 0;
            perr_ev = (lvl > 4) ? 1 : 0;
            @(negedge clk);
            chk("rnd_wr_en", wr_en, en);
            chk("rnd_level", level, lvl);
            chk("rnd_full", full, lvl >= 4);
            chk("rnd_afull", almost_full, lvl >= 2);
            chk("rnd_wr_addr", wr_addr, m_wp % 4);
            m_wp  = flush ? int'(rd_ptr) : (m_wp + en) % 8;
            m_ovf = drop ? 1 : (ovf_clr ? 0 : m_ovf);
            m_pe  = perr_ev ? 1 : (ovf_clr ? 0 : m_pe);
            m_dc  = drop ? (ovf_clr ? 1 : (m_dc == 3 ? 3 : m_dc + 1)) : (ovf_clr ? 0 : m_dc);
            @(posedge clk);
            #1;
            chk("rnd_wr_ptr", wr_ptr, m_wp);
            chk("rnd_overflow", overflow, m_ovf);
            chk("rnd_ptr_err", ptr_err, m_pe);
            chk("rnd_drop_cnt", drop_cnt, m_dc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
